// File: rtl/ds2_responder.sv
// DualShock2 pad emulator: answers a DS2 host poll with ID, 0x5A and button (and stick) bytes.
// Define DS2_ANALOG_EN for the analog-mode frame (ID 0x73, four stick bytes appended).
module ds2_responder #(
    parameter int ACK_DELAY = 8,
    parameter int ACK_WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ds2_att,
    input  logic       ds2_clk,
    input  logic       ds2_cmd,
    output logic       ds2_dat,
    output logic       ds2_ack,
    input  logic [15:0] keys,
    input  logic [7:0] stick_lx,
    input  logic [7:0] stick_ly,
    input  logic [7:0] stick_rx,
    input  logic [7:0] stick_ry,
    output logic [7:0] cmd_byte,
    output logic       cmd_strobe,
    output logic       poll_done
);

`ifdef DS2_ANALOG_EN
    localparam logic [7:0] ID = 8'h73;
    localparam int         N  = 9;
`else
    localparam logic [7:0] ID = 8'h41;
    localparam int         N  = 5;
    logic unused_sticks;
    assign unused_sticks = ^{stick_lx, stick_ly, stick_rx, stick_ry};
`endif

    typedef enum logic [2:0] {IDLE, XFER, ACK_WAIT, ACK, DONE} state_t;

    state_t      state, state_n;
    logic [2:0]  att_q, clk_q;
    logic [1:0]  cmd_q;
    logic [2:0]  bitcnt;
    logic [3:0]  idx;
    logic [7:0]  rx, rx_n, tx_byte;
    logic [15:0] cnt;
    logic [15:0] keys_l;
    logic [7:0]  lx_l, ly_l, rx_l, ry_l;
    logic        frame_ok;
    logic        att_rise, att_fall, clk_rise, clk_fall, last_bit, hdr_bad;

    // Button bytes go out with the first-listed button in bit 0 (wire order),
    // i.e. the reverse of the keys bit order, and active low.
    function automatic logic [7:0] btn_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) btn_byte[i] = ~v[7-i];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            att_q <= 3'b111;
            clk_q <= 3'b111;
            cmd_q <= 2'b11;
        end else begin
            att_q <= {att_q[1:0], ds2_att};
            clk_q <= {clk_q[1:0], ds2_clk};
            cmd_q <= {cmd_q[0], ds2_cmd};
        end
    end

    assign att_rise = att_q[1] & ~att_q[2];
    assign att_fall = ~att_q[1] & att_q[2];
    assign clk_rise = clk_q[1] & ~clk_q[2];
    assign clk_fall = ~clk_q[1] & clk_q[2];
    assign rx_n     = {cmd_q[1], rx[7:1]};
    assign last_bit = clk_rise && (bitcnt == 3'd7);
    assign hdr_bad  = ((idx == 4'd0) && (rx_n != 8'h01)) || ((idx == 4'd1) && (rx_n != 8'h42));

    always_comb begin
        tx_byte = 8'hFF;
        case (idx)
            4'd1: tx_byte = ID;
            4'd2: tx_byte = 8'h5A;
            4'd3: tx_byte = btn_byte(keys_l[7:0]);
            4'd4: tx_byte = btn_byte(keys_l[15:8]);
`ifdef DS2_ANALOG_EN
            4'd5: tx_byte = rx_l;
            4'd6: tx_byte = ry_l;
            4'd7: tx_byte = lx_l;
            4'd8: tx_byte = ly_l;
`endif
            default: tx_byte = 8'hFF;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (att_fall) state_n = XFER;
            XFER:     if (last_bit) state_n = (hdr_bad || idx == 4'(N-1)) ? DONE : ACK_WAIT;
            ACK_WAIT: if (cnt == 16'(ACK_DELAY-1)) state_n = ACK;
            ACK:      if (cnt == 16'(ACK_WIDTH-1)) state_n = XFER;
            default:  state_n = state;
        endcase
        // ATT high always ends the frame, whatever the state
        if (att_rise) state_n = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bitcnt     <= '0;
            idx        <= '0;
            rx         <= '0;
            cnt        <= '0;
            ds2_dat    <= 1'b1;
            ds2_ack    <= 1'b1;
            cmd_byte   <= '0;
            cmd_strobe <= 1'b0;
            poll_done  <= 1'b0;
            frame_ok   <= 1'b0;
            keys_l     <= '0;
            lx_l       <= 8'h80;
            ly_l       <= 8'h80;
            rx_l       <= 8'h80;
            ry_l       <= 8'h80;
        end else begin
            state      <= state_n;
            cmd_strobe <= 1'b0;
            poll_done  <= 1'b0;
            ds2_ack    <= (state_n != ACK);
            cnt        <= (state_n != state) ? 16'd0 : cnt + 16'd1;
            case (state)
                IDLE: begin
                    bitcnt   <= '0;
                    idx      <= '0;
                    frame_ok <= 1'b0;
                    if (att_fall) begin
                        keys_l <= keys;
                        lx_l   <= stick_lx;
                        ly_l   <= stick_ly;
                        rx_l   <= stick_rx;
                        ry_l   <= stick_ry;
                    end
                end
                XFER: begin
                    if (clk_fall) ds2_dat <= tx_byte[bitcnt];
                    if (clk_rise) begin
                        rx     <= rx_n;
                        bitcnt <= bitcnt + 3'd1;
                    end
                    if (last_bit) begin
                        cmd_byte   <= rx_n;
                        cmd_strobe <= 1'b1;
                        if (!hdr_bad && idx == 4'(N-1)) frame_ok <= 1'b1;
                    end
                end
                ACK: if (state_n == XFER && idx != 4'(N-1)) idx <= idx + 4'd1;
                DONE: if (att_rise && frame_ok) poll_done <= 1'b1;
                default: ;
            endcase
            if (state_n == DONE || state_n == IDLE) ds2_dat <= 1'b1;
        end
    end

endmodule
